// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed seven-segment scan driver
module seg7_scan_driver #(
   parameter int DIGIT_PERIOD = 100000,
   parameter int GUARD        = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        frame_start
);

   localparam int            TW        = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_PERIOD - 1);
   localparam logic [TW-1:0] GUARD_T   = TW'(GUARD);

   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    dp_shadow_q, dp_shadow_d;
   logic [6:0]    seg_n_q, seg_n_d;
   logic          dp_n_q, dp_n_d;
   logic [3:0]    an_n_q, an_n_d;
   logic          frame_start_q, frame_start_d;

   logic          capture;
   logic [3:0]    nibble;
   logic [3:0]    lz_blank;

   // Active-low hex glyph, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Slot/digit counters, frame capture and next output values
   always_comb begin
      tick_d        = tick_q + TW'(1);
      idx_d         = idx_q;
      shadow_d      = shadow_q;
      dp_shadow_d   = dp_shadow_q;
      an_n_d        = 4'b1111;
      seg_n_d       = 7'b1111111;
      dp_n_d        = 1'b1;

      if (tick_q == TICK_LAST) begin
         tick_d = '0;
         idx_d  = idx_q + 2'd1;
      end

      // A new frame latches the display data so mid-frame input changes wait
      capture = (idx_q == 2'd0) && (tick_q == '0);
      if (capture) begin
         shadow_d    = digits_in;
         dp_shadow_d = dp_in;
      end
      frame_start_d = capture;

      // A digit is a leading zero when it and every digit to its left are zero
      lz_blank[3] = (shadow_q[15:12] == 4'h0);
      lz_blank[2] = lz_blank[3] && (shadow_q[11:8] == 4'h0);
      lz_blank[1] = lz_blank[2] && (shadow_q[7:4] == 4'h0);
      lz_blank[0] = 1'b0;

      nibble = shadow_q[{idx_q, 2'b00} +: 4];

      if (tick_q >= GUARD_T) begin
         an_n_d  = ~(4'b0001 << idx_q);
         seg_n_d = (blank_lz && lz_blank[idx_q]) ? 7'b1111111 : hex_glyph(nibble);
         dp_n_d  = ~dp_shadow_q[idx_q];
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q        <= '0;
         idx_q         <= 2'd0;
         shadow_q      <= 16'h0000;
         dp_shadow_q   <= 4'b0000;
         an_n_q        <= 4'b1111;
         seg_n_q       <= 7'b1111111;
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         tick_q        <= tick_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         dp_shadow_q   <= dp_shadow_d;
         an_n_q        <= an_n_d;
         seg_n_q       <= seg_n_d;
         dp_n_q        <= dp_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg_n       = seg_n_q;
   assign dp_n        = dp_n_q;
   assign an_n        = an_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The module SHALL have parameter DIGIT_PERIOD, default 100000: clock cycles per digit slot, legal range 4..2^20.
REQ-002 The module SHALL have parameter GUARD, default 1000: anode-off cycles at the start of each slot, legal range 1..DIGIT_PERIOD-2.
REQ-003 The module SHALL have port clk, input, 1 bit: system clock; the block uses this single clock.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port digits_in, input, 16 bits: four nibbles, [3:0] = digit 0 (rightmost), [15:12] = digit 3; driven by the menu subsystem's seven-segment output.
REQ-006 The module SHALL have port dp_in, input, 4 bits: decimal point request per digit, where 1 means lit.
REQ-007 The module SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-008 The module SHALL have port seg_n, output, 7 bits: cathodes {g,f,e,d,c,b,a}, active low.
REQ-009 The module SHALL have port dp_n, output, 1 bit: decimal point cathode, active low.
REQ-010 The module SHALL have port an_n, output, 4 bits: anodes, where an_n[k]=0 enables digit k.
REQ-011 The module SHALL have port frame_start, output, 1 bit: one-cycle pulse marking the first cycle of each frame.

Function
REQ-012 The module SHALL contain slot counter tick (0..DIGIT_PERIOD-1) and digit index idx (0..3).
- tick increments every cycle.
- At tick=DIGIT_PERIOD-1, tick wraps to 0 and idx increments, with 3 wrapping to 0.
REQ-013 The module SHALL contain a 16-bit shadow register and a 4-bit dp shadow register.
- Both load digits_in and dp_in on every clock edge where (idx=0, tick=0) and reset=0.
- They hold at all other times, so a mid-frame input change never appears before the next frame.
REQ-014 frame_start SHALL be registered and equal 1 exactly in the cycle after each capture edge of REQ-013; it is 0 otherwise.
REQ-015 All outputs SHALL be registered and reflect (idx, tick, shadow) of the previous cycle, giving one cycle of latency.
REQ-016 The guard interval SHALL be the cycles with tick<GUARD, during which the outputs are:
- an_n=4'b1111;
- seg_n=7'b1111111;
- dp_n=1.
REQ-017 Outside the guard interval, an_n SHALL be ~(4'b0001<<idx).
REQ-018 Outside the guard interval, seg_n SHALL be the active-low hex glyph of shadow nibble idx:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000;
- 4=0011001, 5=0010010, 6=0000010, 7=1111000;
- 8=0000000, 9=0010000, A=0001000, b=0000011;
- C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 Outside the guard interval, dp_n SHALL be ~dp shadow[idx].
REQ-020 Leading-zero blanking SHALL apply when blank_lz=1, sampled live.
- Digit k (k=3,2,1) is blanked when shadow nibbles k..3 are all zero.
- Digit 0 is never blanked.
- A blanked digit keeps its anode active per REQ-017, with seg_n=7'b1111111; dp_n still follows REQ-019.
REQ-021 The module SHALL use no combinational path from any input to any output.

Reset
REQ-022 While reset=1, on every edge:
- tick=0, idx=0;
- shadow=16'h0000, dp shadow=4'b0000;
- an_n=4'b1111, seg_n=7'b1111111, dp_n=1, frame_start=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame within one edge; the first edge with reset=0 is a capture edge per REQ-013.

Verification (DIGIT_PERIOD=8, GUARD=2)
REQ-024 The bench SHALL cover reset: hold reset 3 cycles with digits_in=16'hFFFF -> an_n=1111, seg_n=1111111, dp_n=1, frame_start=0 throughout; one cycle after release frame_start=1.
REQ-025 The bench SHALL cover the glyph scan: digits_in=16'h1234, blank_lz=0 -> the frame shows:
- digit 0: an_n=1110, seg_n=0011001 for 6 cycles after 2 guard cycles;
- digit 1: seg_n=0110000;
- digit 2: seg_n=0100100;
- digit 3: seg_n=1111001.
REQ-026 The bench SHALL cover leading-zero blanking:
- digits_in=16'h0050, blank_lz=1 -> digits 3 and 2 give seg_n=1111111 with their anode low; digit 1=0010010; digit 0=1000000.
- digits_in=16'h0000 -> only digit 0 shows 1000000.
REQ-027 The bench SHALL cover the decimal point: dp_in=4'b0100 -> dp_n=0 only in the non-guard cycles of the digit 2 slot; dp_n=1 in all other cycles.
REQ-028 The bench SHALL cover the frame boundary: change digits_in from 16'h1111 to 16'h2222 during the digit 1 slot -> digits 1..3 still show 1111001; the next frame (after the frame_start pulse) shows 0100100 on all digits.
REQ-029 The bench SHALL cover reset mid-operation: assert reset during the digit 2 slot -> next edge gives an_n=1111; after release the scan restarts at digit 0 with newly captured data.
